// File: rtl/spi_pixel_receiver.sv
// SPI slave front end that assembles DATA_W-bit pixel words and streams them out
// over a valid/ready handshake, with frame-position sidebands and error status.
module spi_pixel_receiver #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned CPOL      = 0,
    parameter int unsigned CPHA      = 0,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_frame_start,
    output logic              o_frame_end,
    output logic              o_frame_err,
    output logic              o_overflow,
    input  logic              i_clr_status
);

    localparam int unsigned BIT_W  = $clog2(DATA_W);
    localparam int unsigned WORD_W = $clog2(FRAME_LEN);
    localparam logic        IDLE_SCLK = 1'(CPOL);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t state, state_nxt;

    logic [2:0] sclk_sync;
    logic [2:0] cs_sync;
    logic [1:0] mosi_sync;

    logic              armed;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] word_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;

    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge;
    logic cs_n_s, cs_rise, mosi_s;
    logic start_recv, abort, shift_en, word_done, frame_err_c;

    // Synchronizers; reset values chosen so release never looks like an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= {3{IDLE_SCLK}};
            cs_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi_sclk};
            cs_sync   <= {cs_sync[1:0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    assign sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall   = ~sclk_sync[1] & sclk_sync[2];
    assign lead_edge   = (IDLE_SCLK == 1'b0) ? sclk_rise : sclk_fall;
    assign trail_edge  = (IDLE_SCLK == 1'b0) ? sclk_fall : sclk_rise;
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign cs_n_s      = cs_sync[1];
    assign cs_rise     = cs_sync[1] & ~cs_sync[2];
    assign mosi_s      = mosi_sync[1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (armed && !cs_n_s) state_nxt = RECV;
            RECV:    if (cs_rise)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control decode; CS release takes priority over a coincident sample edge
    always_comb begin
        start_recv  = 1'b0;
        abort       = 1'b0;
        shift_en    = 1'b0;
        word_done   = 1'b0;
        frame_err_c = 1'b0;
        case (state)
            IDLE: start_recv = armed && !cs_n_s;
            RECV: begin
                if (cs_rise) begin
                    abort       = 1'b1;
                    frame_err_c = (bit_cnt != '0) || (word_cnt != '0);
                end else if (sample_edge) begin
                    shift_en  = 1'b1;
                    word_done = (bit_cnt == LAST_BIT);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        if (MSB_FIRST != 0) shreg_nxt = {shreg[DATA_W-2:0], mosi_s};
        else                shreg_nxt = {mosi_s, shreg[DATA_W-1:1]};
    end

    // Armed only after CS is seen high while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         armed <= 1'b0;
        else if (start_recv)                armed <= 1'b0;
        else if (state == IDLE && cs_n_s)   armed <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
            shreg    <= '0;
        end else if (start_recv || abort) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= shreg_nxt;
            bit_cnt <= word_done ? '0 : bit_cnt + BIT_W'(1);
            if (word_done)
                word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + WORD_W'(1);
        end
    end

    // Output stage: load on free/accepted slot, otherwise drop and flag overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_end   <= 1'b0;
            o_frame_err   <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            o_frame_err <= frame_err_c;
            if (word_done && (!o_valid || i_ready)) begin
                o_data        <= shreg_nxt;
                o_valid       <= 1'b1;
                o_frame_start <= (word_cnt == '0);
                o_frame_end   <= (word_cnt == LAST_WORD);
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            if (word_done && o_valid && !i_ready) o_overflow <= 1'b1;
            else if (i_clr_status)                o_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_pixel_receiver.sv
// Directed bench: instance 0 is mode 0 MSB-first, instance 1 is CPOL=1/CPHA=1 LSB-first,
// both with FRAME_LEN=4 so frame wrap is reachable.
module tb_spi_pixel_receiver;

    logic       clk;
    logic       rst_n;
    logic       sclk  [2];
    logic       mosi  [2];
    logic       cs_n  [2];
    logic [7:0] data  [2];
    logic       valid [2];
    logic       ready [2];
    logic       fs    [2];
    logic       fe    [2];
    logic       ferr  [2];
    logic       ovf   [2];
    logic       clr   [2];

    int n_checks = 0;
    int n_pass   = 0;
    int vcyc [2];
    int ecyc [2];
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    logic [9:0] ent;

    spi_pixel_receiver #(.DATA_W(8), .FRAME_LEN(4), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_cs_n(cs_n[0]),
        .o_data(data[0]), .o_valid(valid[0]), .i_ready(ready[0]), .o_frame_start(fs[0]),
        .o_frame_end(fe[0]), .o_frame_err(ferr[0]), .o_overflow(ovf[0]), .i_clr_status(clr[0]));

    spi_pixel_receiver #(.DATA_W(8), .FRAME_LEN(4), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_cs_n(cs_n[1]),
        .o_data(data[1]), .o_valid(valid[1]), .i_ready(ready[1]), .o_frame_start(fs[1]),
        .o_frame_end(fe[1]), .o_frame_err(ferr[1]), .o_overflow(ovf[1]), .i_clr_status(clr[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record accepted words and count valid / frame_err cycles
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (valid[d]) begin
                vcyc[d] = vcyc[d] + 1;
                if (ready[d]) begin
                    if (d == 0) q0.push_back({fs[d], fe[d], data[d]});
                    else        q1.push_back({fs[d], fe[d], data[d]});
                end
            end
            if (ferr[d]) ecyc[d] = ecyc[d] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Half SCLK period = 4 system clocks (f_sclk = f_clk/8)
    task automatic hp();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            vcyc[d] = 0;
            ecyc[d] = 0;
        end
    endtask

    task automatic send_word(input int d, input logic [7:0] w, input int nbits);
        logic b;
        logic cpol;
        cpol = (d == 1);
        for (int i = 0; i < nbits; i++) begin
            b = (d == 0) ? w[7-i] : w[i];
            if (d == 0) begin
                mosi[d] = b;
                hp();
                sclk[d] = ~cpol;
                hp();
                sclk[d] = cpol;
            end else begin
                sclk[d] = ~cpol;
                mosi[d] = b;
                hp();
                sclk[d] = cpol;
                hp();
            end
        end
    endtask

    task automatic cs_low(input int d);
        cs_n[d] = 1'b0;
        hp();
    endtask

    task automatic cs_high(input int d);
        hp();
        cs_n[d] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] pop0();
        if (q0.size() > 0) return q0.pop_front();
        return 10'h3ff;
    endfunction

    initial begin
        rst_n = 1'b0;
        sclk[0] = 1'b0; sclk[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mosi[d] = 1'b0; cs_n[d] = 1'b1; ready[d] = 1'b1; clr[d] = 1'b0;
            vcyc[d] = 0; ecyc[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid[0]), 0);
        check("rst_data", 32'(data[0]), 0);
        check("rst_fs", 32'(fs[0]), 0);
        check("rst_ovf", 32'(ovf[0]), 0);
        check("rst_ferr", 32'(ferr[1]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hp();

        // Mode 0, single word 0xA5
        clear_mon();
        cs_low(0);
        send_word(0, 8'hA5, 8);
        cs_high(0);
        check("m0_count", 32'(q0.size()), 1);
        ent = pop0();
        check("m0_data", 32'(ent[7:0]), 32'hA5);
        check("m0_start", 32'(ent[9]), 1);
        check("m0_end", 32'(ent[8]), 0);
        check("m0_vcyc", 32'(vcyc[0]), 1);
        check("m0_ferr", 32'(ecyc[0]), 1);

        // CPOL=1 CPHA=1 LSB-first, 0x3C
        clear_mon();
        cs_low(1);
        send_word(1, 8'h3C, 8);
        cs_high(1);
        check("m3_count", 32'(q1.size()), 1);
        ent = (q1.size() > 0) ? q1.pop_front() : 10'h3ff;
        check("m3_data", 32'(ent[7:0]), 32'h3C);

        // Nine words under one CS, FRAME_LEN=4
        clear_mon();
        cs_low(0);
        for (int i = 0; i < 9; i++) send_word(0, 8'(8'h10 + i), 8);
        cs_high(0);
        check("fr_count", 32'(q0.size()), 9);
        for (int i = 0; i < 9; i++) begin
            ent = pop0();
            check($sformatf("fr_data%0d", i), 32'(ent[7:0]), 32'(8'h10 + i));
            check($sformatf("fr_start%0d", i), 32'(ent[9]), 32'((i % 4) == 0));
            check($sformatf("fr_end%0d", i), 32'(ent[8]), 32'((i % 4) == 3));
        end
        check("fr_ferr", 32'(ecyc[0]), 1);

        // Backpressure: second word dropped, overflow sticky until cleared
        clear_mon();
        ready[0] = 1'b0;
        cs_low(0);
        send_word(0, 8'h5A, 8);
        send_word(0, 8'hC3, 8);
        cs_high(0);
        check("ov_valid", 32'(valid[0]), 1);
        check("ov_data", 32'(data[0]), 32'h5A);
        check("ov_flag", 32'(ovf[0]), 1);
        clr[0] = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0;
        check("ov_clr", 32'(ovf[0]), 0);
        check("ov_hold", 32'(valid[0]), 1);
        ready[0] = 1'b1;
        @(posedge clk); #1;
        check("ov_accept_n", 32'(q0.size()), 1);
        ent = pop0();
        check("ov_accept_d", 32'(ent[7:0]), 32'h5A);
        check("ov_drop", 32'(valid[0]), 0);

        // CS abort after 3 bits of word 2
        clear_mon();
        cs_low(0);
        send_word(0, 8'h11, 8);
        send_word(0, 8'h22, 8);
        send_word(0, 8'h33, 3);
        cs_high(0);
        check("ab_count", 32'(q0.size()), 2);
        check("ab_vcyc", 32'(vcyc[0]), 2);
        check("ab_ferr", 32'(ecyc[0]), 1);
        check("ab_data", 32'(data[0]), 32'h22);

        // Reset mid-word with CS low; must re-see CS high before receiving
        clear_mon();
        cs_low(0);
        send_word(0, 8'hF0, 4);
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_valid", 32'(valid[0]), 0);
        check("mr_data", 32'(data[0]), 0);
        check("mr_fs", 32'(fs[0]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_word(0, 8'hFF, 8);
        hp();
        check("mr_ignored", 32'(q0.size()), 0);
        check("mr_novalid", 32'(valid[0]), 0);
        cs_high(0);
        clear_mon();
        cs_low(0);
        send_word(0, 8'h66, 8);
        cs_high(0);
        check("mr_count", 32'(q0.size()), 1);
        ent = pop0();
        check("mr_data2", 32'(ent[7:0]), 32'h66);
        check("mr_start", 32'(ent[9]), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
